// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart TX FIFO write port among NUM_REQ requesters. Round-robin
//   arbitration at packet granularity: the grant is held from the first word
//   until the word flagged last, so packets never interleave. A stall watchdog
//   reclaims the grant from a requester that goes quiet mid-packet.
// Ports
//   clk, rst     clock, synchronous active-high reset
//   req_valid    per-requester word valid
//   req_data     requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     word is final word of its packet
//   req_ready    word accepted this cycle when valid & ready (combinational)
//   tx_data      word to uart (combinational, 0 when tx_write is low)
//   tx_write     write strobe to uart (combinational)
//   tx_full      uart FIFO full
//   grant        registered one-hot owner of the port (0 when idle)
//   busy         high while a packet owns the port
//   timeout_err  one-cycle pulse when the watchdog releases a grant
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_write,
  input  logic                          tx_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Width $clog2(TIMEOUT+1); one bit minimum keeps TIMEOUT=0 legal.
  localparam int unsigned CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   timeout_err_q, timeout_err_d;

  logic [DATA_WIDTH-1:0]  words [NUM_REQ];
  logic [PTR_W-1:0]       rr_sel;
  logic                   rr_found;
  int unsigned            rr_idx;
  logic                   xfer;

  // Unpack the flat requester data bus.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search: first valid requester after the last owner.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_idx   = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      rr_idx = 32'(ptr_q) + off;
      if (rr_idx >= NUM_REQ) begin
        rr_idx = rr_idx - NUM_REQ;
      end
      if (!rr_found && req_valid[PTR_W'(rr_idx)]) begin
        rr_found = 1'b1;
        rr_sel   = PTR_W'(rr_idx);
      end
    end
  end

  // Next-state, watchdog and combinational write-port logic.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    req_ready     = '0;
    xfer          = 1'b0;
    tx_write      = 1'b0;
    tx_data       = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rr_found) begin
          state_d         = SEND;
          owner_d         = rr_sel;
          grant_d         = '0;
          grant_d[rr_sel] = 1'b1;
        end
      end

      SEND: begin
        req_ready[owner_q] = !tx_full;
        xfer               = req_valid[owner_q] && !tx_full;
        if (xfer) begin
          cnt_d = '0;
          if (req_last[owner_q]) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = owner_q;
          end
        end else if ((TIMEOUT > 0) && !req_valid[owner_q] && !tx_full) begin
          // Only owner-silent cycles count; backpressure never does.
          if (cnt_q == CNT_W'(TMO_LAST)) begin
            state_d       = IDLE;
            grant_d       = '0;
            ptr_d         = owner_q;
            timeout_err_d = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset blocks the write port in the same cycle it is asserted.
    if (rst) begin
      req_ready = '0;
    end
    tx_write = xfer && !rst;
    if (tx_write) begin
      tx_data = words[owner_q];
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      ptr_q         <= PTR_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q == SEND);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed scenarios plus a randomized run checked against a cycle-level
//   behavioural model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 4;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    tx_data;
  logic             tx_write;
  logic             tx_full;
  logic [NR-1:0]    grant;
  logic             busy;
  logic             timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench time limit");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_full   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    req_valid = 4'hF;
    next_cycle();
    next_cycle();
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (tx_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", tx_write); end
    clear_inputs();
  endtask

  task automatic test_three_word();
    do_reset();
    req_valid = 4'b0001; req_data[7:0] = 8'hA1;
    #1;
    checks++; if (tx_write !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL tw_idle: write %b ready %b expected 0 0000", tx_write, req_ready); end
    next_cycle(); #1;
    checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL tw_grant: grant %b busy %b expected 0001 1", grant, busy); end
    checks++; if (tx_write !== 1'b1 || tx_data !== 8'hA1) begin errors++; $display("FAIL tw_w1: write %b data %h expected 1 a1", tx_write, tx_data); end
    next_cycle(); req_data[7:0] = 8'hA2; #1;
    checks++; if (tx_write !== 1'b1 || tx_data !== 8'hA2) begin errors++; $display("FAIL tw_w2: write %b data %h expected 1 a2", tx_write, tx_data); end
    next_cycle(); req_data[7:0] = 8'hA3; req_last = 4'b0001; #1;
    checks++; if (tx_write !== 1'b1 || tx_data !== 8'hA3) begin errors++; $display("FAIL tw_w3: write %b data %h expected 1 a3", tx_write, tx_data); end
    next_cycle(); clear_inputs(); #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || tx_write !== 1'b0) begin errors++; $display("FAIL tw_release: grant %b busy %b write %b expected 0000 0 0", grant, busy, tx_write); end
  endtask

  // Req0 and req2 each queue two 2-word packets; round-robin must alternate.
  task automatic test_back_to_back();
    int          widx [NR];
    logic [7:0]  exp_q [$];
    int          src_q [$];
    logic [7:0]  w;
    int          s;
    bit          prev_last;
    do_reset();
    exp_q = '{8'h00, 8'h01, 8'h20, 8'h21, 8'h02, 8'h03, 8'h22, 8'h23};
    src_q = '{0, 0, 2, 2, 0, 0, 2, 2};
    for (int r = 0; r < NR; r++) widx[r] = 0;
    prev_last = 1'b0;
    for (int c = 0; c < 40; c++) begin
      for (int r = 0; r < NR; r += 2) begin
        req_valid[r]         = (widx[r] < 4);
        req_data[r*DW +: DW] = {4'(r), 4'(widx[r])};
        req_last[r]          = widx[r][0];
      end
      #1;
      if (prev_last) begin
        checks++; if (tx_write !== 1'b0) begin errors++; $display("FAIL rr_gap: write %b expected 0 after last word", tx_write); end
      end
      if (tx_write === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rr_extra: write data %h with nothing expected", tx_data);
        end else begin
          w = exp_q.pop_front();
          s = src_q.pop_front();
          if (tx_data !== w || grant !== 4'(1 << s)) begin
            errors++; $display("FAIL rr_order: data %h grant %b expected %h %b", tx_data, grant, w, 4'(1 << s));
          end
        end
      end
      prev_last = (tx_write === 1'b1) && ((req_last & req_ready & req_valid) != 0);
      for (int r = 0; r < NR; r++) if (req_valid[r] && req_ready[r]) widx[r]++;
      next_cycle();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_incomplete: %0d words missing expected 0", exp_q.size()); end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0010; req_data[15:8] = 8'hB0;
    next_cycle(); #1;
    checks++; if (grant !== 4'b0010 || tx_write !== 1'b1 || tx_data !== 8'hB0) begin errors++; $display("FAIL bp_first: grant %b write %b data %h expected 0010 1 b0", grant, tx_write, tx_data); end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      tx_full = 1'b1; req_valid = 4'b0000; req_data[15:8] = 8'hB1;
      #1;
      checks++;
      if (req_ready !== 4'b0000 || tx_write !== 1'b0 || timeout_err !== 1'b0 || grant !== 4'b0010) begin
        errors++; $display("FAIL bp_stall%0d: ready %b write %b terr %b grant %b expected 0000 0 0 0010", i, req_ready, tx_write, timeout_err, grant);
      end
    end
    next_cycle(); tx_full = 1'b0; req_valid = 4'b0010; #1;
    checks++; if (tx_write !== 1'b1 || tx_data !== 8'hB1) begin errors++; $display("FAIL bp_resume: write %b data %h expected 1 b1", tx_write, tx_data); end
    next_cycle(); req_data[15:8] = 8'hB2; req_last = 4'b0010; #1;
    checks++; if (tx_write !== 1'b1 || tx_data !== 8'hB2) begin errors++; $display("FAIL bp_last: write %b data %h expected 1 b2", tx_write, tx_data); end
    next_cycle(); clear_inputs(); #1;
    checks++; if (grant !== 4'b0000 || timeout_err !== 1'b0) begin errors++; $display("FAIL bp_done: grant %b terr %b expected 0000 0", grant, timeout_err); end
  endtask

  task automatic test_watchdog();
    do_reset();
    req_valid = 4'b1010; req_data[15:8] = 8'hC0; req_data[31:24] = 8'hD0; req_last = 4'b1000;
    next_cycle(); #1;
    checks++; if (grant !== 4'b0010 || tx_write !== 1'b1 || tx_data !== 8'hC0) begin errors++; $display("FAIL wd_first: grant %b write %b data %h expected 0010 1 c0", grant, tx_write, tx_data); end
    for (int i = 0; i < 4; i++) begin
      next_cycle(); req_valid = 4'b1000; #1;
      checks++;
      if (grant !== 4'b0010 || timeout_err !== 1'b0 || tx_write !== 1'b0) begin
        errors++; $display("FAIL wd_wait%0d: grant %b terr %b write %b expected 0010 0 0", i, grant, timeout_err, tx_write);
      end
    end
    next_cycle(); #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL wd_fire: grant %b busy %b terr %b expected 0000 0 1", grant, busy, timeout_err); end
    next_cycle(); #1;
    checks++; if (grant !== 4'b1000 || timeout_err !== 1'b0 || tx_write !== 1'b1 || tx_data !== 8'hD0) begin errors++; $display("FAIL wd_next: grant %b terr %b write %b data %h expected 1000 0 1 d0", grant, timeout_err, tx_write, tx_data); end
    next_cycle(); clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0100; req_data[23:16] = 8'hE0;
    next_cycle(); #1;
    checks++; if (grant !== 4'b0100 || tx_write !== 1'b1 || tx_data !== 8'hE0) begin errors++; $display("FAIL rm_first: grant %b write %b data %h expected 0100 1 e0", grant, tx_write, tx_data); end
    next_cycle(); req_data[23:16] = 8'hE1; rst = 1'b1; #1;
    checks++; if (tx_write !== 1'b0 || req_ready !== 4'b0000 || tx_data !== 8'h00) begin errors++; $display("FAIL rm_same: write %b ready %b data %h expected 0 0000 00", tx_write, req_ready, tx_data); end
    next_cycle(); #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || tx_write !== 1'b0) begin errors++; $display("FAIL rm_after: grant %b busy %b write %b expected 0000 0 0", grant, busy, tx_write); end
    rst = 1'b0; req_valid = 4'b0101;
    next_cycle(); #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rm_prio: grant %b expected 0001", grant); end
    clear_inputs();
    next_cycle();
  endtask

  // Randomized traffic against a cycle-level model of the arbitration rules.
  task automatic test_random();
    int         owner, ptr, stall, pkt_src, c, src;
    bit         err, xfer, found;
    logic [3:0] exp_grant, exp_ready;
    logic [7:0] exp_data;
    do_reset();
    owner = -1; ptr = NR - 1; stall = 0; err = 1'b0; pkt_src = -1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rst      = ($urandom_range(0, 999) == 0);
      req_data = $urandom;
      for (int r = 0; r < NR; r++) begin
        req_valid[r] = ($urandom_range(0, 9) < 7);
        req_last[r]  = ($urandom_range(0, 9) < 3);
      end
      tx_full = ($urandom_range(0, 4) == 0);
      #1;
      exp_grant = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
      exp_ready = '0; exp_data = '0; xfer = 1'b0;
      if (!rst && owner >= 0) begin
        exp_ready[owner] = !tx_full;
        xfer = req_valid[owner] && !tx_full;
        if (xfer) exp_data = req_data[owner*DW +: DW];
      end
      checks++; if (grant !== exp_grant) begin errors++; $display("FAIL rnd_grant@%0d: got %b expected %b", cyc, grant, exp_grant); end
      checks++; if (busy !== (owner >= 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %b expected %b", cyc, busy, owner >= 0); end
      checks++; if (timeout_err !== err) begin errors++; $display("FAIL rnd_terr@%0d: got %b expected %b", cyc, timeout_err, err); end
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, req_ready, exp_ready); end
      checks++; if (tx_write !== xfer || tx_data !== exp_data) begin errors++; $display("FAIL rnd_write@%0d: write %b data %h expected %b %h", cyc, tx_write, tx_data, xfer, exp_data); end
      checks++; if (!$onehot0(grant)) begin errors++; $display("FAIL rnd_onehot@%0d: grant %b expected one-hot or zero", cyc, grant); end
      checks++; if (tx_write === 1'b1 && tx_full === 1'b1) begin errors++; $display("FAIL rnd_full_write@%0d: write %b while full expected 0", cyc, tx_write); end
      if (tx_write === 1'b1) begin
        src = $clog2(int'(grant));
        checks++;
        if (pkt_src >= 0 && pkt_src != src) begin errors++; $display("FAIL rnd_interleave@%0d: word from %0d expected %0d", cyc, src, pkt_src); end
        pkt_src = req_last[src] ? -1 : src;
      end
      // Model update at the coming clock edge.
      if (rst) begin
        owner = -1; ptr = NR - 1; stall = 0; err = 1'b0; pkt_src = -1;
      end else if (owner < 0) begin
        err = 1'b0; found = 1'b0; stall = 0;
        for (int k = 1; k <= NR; k++) begin
          c = (ptr + k) % NR;
          if (!found && req_valid[c]) begin found = 1'b1; owner = c; end
        end
      end else begin
        err = 1'b0;
        if (xfer) begin
          stall = 0;
          if (req_last[owner]) begin ptr = owner; owner = -1; end
        end else if (!req_valid[owner] && !tx_full) begin
          stall++;
          if (stall == TMO) begin
            ptr = owner; owner = -1; err = 1'b1; stall = 0; pkt_src = -1;
          end
        end
      end
      next_cycle();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_three_word();
    test_back_to_back();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
